// File: rtl/demux1_to_8_32.sv
// Registered 1-to-8 router: one valid/ready input steered by {s2,s1,s0} into eight one-entry channels; 1-cycle latency.
// in_ready stalls only on the selected channel; optional DEMUX_BYPASS_EN passes a word straight through to an empty, ready channel.
module demux1_to_8_32 #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             s2,
  input  logic             s1,
  input  logic             s0,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [3:0]       occupancy
);

  logic [2:0]       sel;
  logic [NCH-1:0]   sel_oh;
  logic [NCH-1:0]   v_q;
  logic [NCH-1:0]   v_nxt;
  logic [NCH-1:0]   drain;
  logic [3:0]       occ_q;
  logic [3:0]       occ_nxt;
  logic [WIDTH-1:0] dat_q [NCH];
  logic [WIDTH-1:0] dout  [NCH];
  logic             accept;
  logic             load;

  assign sel      = {s2, s1, s0};
  assign sel_oh   = {{(NCH-1){1'b0}}, 1'b1} << sel;
  assign in_ready = ~v_q[sel] | out_ready[sel];
  assign accept   = in_valid & in_ready;
  assign drain    = v_q & out_ready;

`ifdef DEMUX_BYPASS_EN
  logic bypass;
  // An empty channel whose consumer is ready takes the word this cycle; nothing is stored.
  assign bypass = in_valid & ~v_q[sel] & out_ready[sel];
  assign load   = accept & ~bypass;
`else
  assign load   = accept;
`endif

  // Drain clears a channel unless the same edge reloads it, which keeps back-to-back transfers bubble-free.
  always_comb begin
    v_nxt = (v_q & ~drain) | (load ? sel_oh : '0);
    occ_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      occ_nxt = occ_nxt + {3'b000, v_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      v_q   <= v_nxt;
      occ_q <= occ_nxt;
      if (load) begin
        dat_q[sel] <= in;
      end
    end
  end

  always_comb begin
    dout      = dat_q;
    out_valid = v_q;
`ifdef DEMUX_BYPASS_EN
    if (bypass) begin
      dout[sel] = in;
      out_valid = v_q | sel_oh;
    end
`endif
  end

  assign occupancy = occ_q;
  assign out0 = dout[0];
  assign out1 = dout[1];
  assign out2 = dout[2];
  assign out3 = dout[3];
  assign out4 = dout[4];
  assign out5 = dout[5];
  assign out6 = dout[6];
  assign out7 = dout[7];

endmodule

// File: tb/tb_demux1_to_8_32.sv
// Scoreboard bench for demux1_to_8_32: stimulus pushes expected words per channel, a negedge monitor checks each delivery.
module tb_demux1_to_8_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in;
  logic        s2, s1, s0;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [3:0]  occupancy;

  wire  [31:0] outs [8];
  assign outs[0] = out0; assign outs[1] = out1; assign outs[2] = out2; assign outs[3] = out3;
  assign outs[4] = out4; assign outs[5] = out5; assign outs[6] = out6; assign outs[7] = out7;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] q [8][$];

  always #5 clk = ~clk;

  demux1_to_8_32 dut (
    .clk(clk), .rst_n(rst_n), .in(in), .s2(s2), .s1(s1), .s0(s0),
    .in_valid(in_valid), .in_ready(in_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7),
    .out_valid(out_valid), .out_ready(out_ready), .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every delivered word must match the oldest expected word for its channel.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 8; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (q[k].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_delivery ch%0d: got %h expected none", k, outs[k]);
          end else begin
            chk($sformatf("deliver_ch%0d", k), outs[k], q[k].pop_front());
          end
        end
      end
    end
  end

  task automatic put(input int ch, input logic [31:0] d);
    {s2, s1, s0} = 3'(ch);
    in           = d;
    in_valid     = 1'b1;
    q[ch].push_back(d);
  endtask

  // Returns at posedge+1 once the held word has been taken, or flags a timeout.
  task automatic wait_accept(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no accept expected accept within %0d cycles", name, budget);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in = '0; {s2, s1, s0} = 3'b000; in_valid = 1'b0; out_ready = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_occupancy", 32'(occupancy), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single route to channel 5
    put(5, 32'hDEADBEEF);
    wait_accept(2, "single_accept");
    in_valid = 1'b0;
    chk("single_out5", out5, 32'hDEADBEEF);
    chk("single_out_valid", 32'(out_valid), 32'h20);
    chk("single_occupancy", 32'(occupancy), 32'd1);
    chk("single_out0_unchanged", out0, 32'h0);
    chk("single_out7_unchanged", out7, 32'h0);

    // Backpressure on full channel 5
    put(5, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'h0);
      chk($sformatf("bp_out5_held_%0d", i), out5, 32'hDEADBEEF);
    end
    @(posedge clk);
    #1;
    out_ready[5] = 1'b1;
    wait_accept(1, "bp_accept");
    out_ready[5] = 1'b0;
    in_valid     = 1'b0;
    chk("bp_out5", out5, 32'h12345678);
    chk("bp_out_valid", 32'(out_valid), 32'h20);
    chk("bp_occupancy", 32'(occupancy), 32'd1);
    out_ready[5] = 1'b1;
    idle_cycle();
    out_ready[5] = 1'b0;
    chk("bp_drained_occ", 32'(occupancy), 32'd0);

    // Back-to-back on channel 2 with consumer always ready
    out_ready = 8'h04;
    for (int i = 1; i <= 4; i++) begin
      put(2, 32'(i));
      @(negedge clk);
      chk($sformatf("b2b_in_ready_%0d", i), 32'(in_ready), 32'h1);
      if (i > 1) chk($sformatf("b2b_valid_%0d", i), 32'(out_valid[2]), 32'h1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("b2b_last_valid", 32'(out_valid), 32'h04);
    chk("b2b_out2_last", out2, 32'd4);
    idle_cycle();
    out_ready = '0;
    chk("b2b_empty", 32'(out_valid), 32'h0);

    // Fill all eight channels then drain them in one cycle
    for (int k = 0; k < 8; k++) begin
      put(k, 32'(k) + 32'h100);
      wait_accept(2, $sformatf("fill_accept_%0d", k));
    end
    in_valid = 1'b0;
    chk("fill_occupancy", 32'(occupancy), 32'd8);
    chk("fill_out_valid", 32'(out_valid), 32'hFF);
    chk("fill_out6", out6, 32'h106);
    out_ready = 8'hFF;
    idle_cycle();
    out_ready = '0;
    chk("drain_occupancy", 32'(occupancy), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'h0);
    chk("drain_out3_kept", out3, 32'h103);

`ifdef DEMUX_BYPASS_EN
    out_ready = 8'h02;
    put(1, 32'hCAFEF00D);
    #1;
    chk("byp_out1", out1, 32'hCAFEF00D);
    chk("byp_valid1", 32'(out_valid[1]), 32'h1);
    chk("byp_occupancy", 32'(occupancy), 32'd0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = '0;
    chk("byp_after_occ", 32'(occupancy), 32'd0);
    chk("byp_after_valid", 32'(out_valid), 32'h0);
`endif

    // Asynchronous reset mid-cycle with channel 3 full
    put(3, 32'hA5A5A5A5);
    wait_accept(2, "rst_fill_accept");
    in_valid = 1'b0;
    chk("rst_pre_valid", 32'(out_valid), 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_occupancy", 32'(occupancy), 32'd0);
    chk("arst_out3", out3, 32'h0);
    for (int s = 0; s < 8; s++) begin
      {s2, s1, s0} = 3'(s);
      #1;
      chk($sformatf("arst_in_ready_sel%0d", s), 32'(in_ready), 32'h1);
    end
    for (int k = 0; k < 8; k++) q[k].delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 8; k++) begin
      chk($sformatf("scoreboard_empty_ch%0d", k), 32'(q[k].size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
